// File: rtl/tile_pkg.sv
// Shared types and constants for the tile hit judge.
// Lane keycodes, coordinate width and game state encoding.
package tile_pkg;

  localparam int COORD_W   = 10;
  localparam int NUM_LANES = 4;

  localparam logic [10:0] HIT_Y_MIN_D   = 11'd380;
  localparam logic [10:0] HIT_Y_MAX_D   = 11'd479;
  localparam logic [1:0]  START_LIVES_D = 2'd3;

  localparam logic [7:0] KEY_L0 = 8'h04;
  localparam logic [7:0] KEY_L1 = 8'h16;
  localparam logic [7:0] KEY_L2 = 8'h07;
  localparam logic [7:0] KEY_L3 = 8'h09;

  typedef enum logic [1:0] {
    WAIT_START,
    PLAY,
    OVER
  } state_e;

endpackage

// File: rtl/tile_hit_judge_lane_judge.sv
// Per-lane hit-zone tracker: judges presses and detects
// tiles that leave the zone without being played.
module lane_judge
  import tile_pkg::*;
#(
  parameter logic [10:0] Y_MIN = HIT_Y_MIN_D,
  parameter logic [10:0] Y_MAX = HIT_Y_MAX_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] s,
  input  logic               press,
  input  logic               play_en,
  output logic               hit,
  output logic [1:0]         miss
);

  logic [10:0] bot_y;
  logic [10:0] top_y;
  logic        in_zone_now;
  logic        wrong;
  logic        exit_miss;
  logic        in_zone_q, in_zone_d;
  logic        judged_q, judged_d;

  always_comb begin
    bot_y = {1'b0, y} + {1'b0, s};
    top_y = (y >= s) ? {1'b0, y - s} : 11'd0;
    in_zone_now = (bot_y >= Y_MIN) && (top_y <= Y_MAX);
    hit   = play_en && press && in_zone_now && !judged_q;
    wrong = play_en && press && (!in_zone_now || judged_q);
    exit_miss = play_en && in_zone_q && !in_zone_now
                && !judged_q;
    // a wrong press and an unplayed exit are separate misses
    miss = {1'b0, wrong} + {1'b0, exit_miss};
    in_zone_d = in_zone_now;
    judged_d  = judged_q;
    if (!in_zone_now) begin
      judged_d = 1'b0;
    end else if (hit) begin
      judged_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_zone_q <= 1'b0;
      judged_q  <= 1'b0;
    end else begin
      in_zone_q <= in_zone_d;
      judged_q  <= judged_d;
    end
  end

endmodule

// File: rtl/tile_hit_judge.sv
// Game judge: key edge detect, FSM, score and lives.
// Build with TILE_COMBO_EN to enable the combo multiplier.
module tile_hit_judge
  import tile_pkg::*;
#(
  parameter logic [10:0] HIT_Y_MIN   = HIT_Y_MIN_D,
  parameter logic [10:0] HIT_Y_MAX   = HIT_Y_MAX_D,
  parameter logic [1:0]  START_LIVES = START_LIVES_D
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  input  logic [39:0] TileY,
  input  logic [39:0] TileS,
  output logic [15:0] Score,
  output logic [1:0]  Lives,
  output logic        GameOver,
  output logic        Playing,
  output logic [3:0]  HitFlash,
  output logic [7:0]  Combo
);

  state_e      state_q, state_d;
  logic [7:0]  prev_key_q, prev_key_d;
  logic [15:0] score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic [3:0]  flash_q, flash_d;

  logic [3:0]  key_hit;
  logic [3:0]  press_lane;
  logic        play_en;
  logic [3:0]  hits;
  logic [3:0][1:0] miss_n;
  logic [3:0]  miss_sum;
  logic [15:0] incr;
  logic [16:0] score_sum;

  always_comb begin
    key_hit[0] = (keycode == KEY_L0);
    key_hit[1] = (keycode == KEY_L1);
    key_hit[2] = (keycode == KEY_L2);
    key_hit[3] = (keycode == KEY_L3);
    press_lane = (keycode != prev_key_q) ? key_hit : 4'b0;
  end

  assign play_en = (state_q == PLAY);

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    lane_judge #(
      .Y_MIN(HIT_Y_MIN),
      .Y_MAX(HIT_Y_MAX)
    ) u_lane (
      .clk    (frame_clk),
      .rst    (Reset),
      .y      (TileY[10*n +: COORD_W]),
      .s      (TileS[10*n +: COORD_W]),
      .press  (press_lane[n]),
      .play_en(play_en),
      .hit    (hits[n]),
      .miss   (miss_n[n])
    );
  end

  always_comb begin
    miss_sum = 4'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      miss_sum = miss_sum + {2'b0, miss_n[i]};
    end
  end

`ifdef TILE_COMBO_EN
  logic [7:0] combo_q, combo_d;
  logic [7:0] combo_step;

  always_comb begin
    combo_step = combo_q >> 3;
    if (combo_step > 8'd3) begin
      combo_step = 8'd3;
    end
    incr = 16'd1 + {8'd0, combo_step};
    combo_d = combo_q;
    unique case (state_q)
      WAIT_START: if (|press_lane) combo_d = 8'd0;
      PLAY: begin
        if (|miss_sum) begin
          combo_d = 8'd0;
        end else if (|hits && combo_q != 8'hFF) begin
          combo_d = combo_q + 8'd1;
        end
      end
      default: combo_d = combo_q;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) combo_q <= 8'd0;
    else       combo_q <= combo_d;
  end

  assign Combo = combo_q;
`else
  assign incr  = 16'd1;
  assign Combo = 8'd0;
`endif

  assign score_sum = {1'b0, score_q} + {1'b0, incr};

  always_comb begin
    state_d    = state_q;
    prev_key_d = keycode;
    score_d    = score_q;
    lives_d    = lives_q;
    flash_d    = flash_q;
    unique case (state_q)
      WAIT_START: begin
        flash_d = 4'b0;
        if (|press_lane) begin
          state_d = PLAY;
          score_d = 16'd0;
          lives_d = START_LIVES;
        end
      end
      PLAY: begin
        flash_d = hits;
        if (|hits) begin
          score_d = score_sum[16] ? 16'hFFFF
                                  : score_sum[15:0];
        end
        if ({2'b0, lives_q} > miss_sum) begin
          lives_d = lives_q - miss_sum[1:0];
        end else begin
          lives_d = 2'd0;
        end
        if (lives_d == 2'd0) begin
          state_d = OVER;
        end
      end
      OVER: state_d = OVER;
      default: state_d = WAIT_START;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= WAIT_START;
      prev_key_q <= 8'd0;
      score_q    <= 16'd0;
      lives_q    <= START_LIVES;
      flash_q    <= 4'b0;
    end else begin
      state_q    <= state_d;
      prev_key_q <= prev_key_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      flash_q    <= flash_d;
    end
  end

  assign Score    = score_q;
  assign Lives    = lives_q;
  assign GameOver = (state_q == OVER);
  assign Playing  = (state_q == PLAY);
  assign HitFlash = flash_q;

endmodule
